// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg
// Shared definitions for the RAM responder:
//   - MSIZE encodings (byte / halfword / word / reserved-as-word)
//   - handshake state encoding (IDLE, WAIT, DONE)
//   - default DEPTH_BYTES and WAIT_CYCLES values
//   - wait-counter width and a load-extension helper
package ram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE_BYTE = 2'b00,
        MSIZE_HALF = 2'b01,
        MSIZE_WORD = 2'b10,
        MSIZE_RSVD = 2'b11   // behaves exactly like MSIZE_WORD
    } msize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int DEF_DEPTH_BYTES = 256;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;   // holds WAIT_CYCLES 0..15

    // Right-justify a byte (val[7:0]) or halfword (val[15:0]) into 32 bits,
    // replicating the top bit only when sign extension is requested.
    function automatic logic [31:0] extend_load(input logic [15:0] val,
                                                input logic        is_half,
                                                input logic        sign_ext);
        logic [31:0] res;
        if (is_half) begin
            res = {{16{sign_ext & val[15]}}, val};
        end else begin
            res = {{24{sign_ext & val[7]}}, val[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// ram_lane_align
// Combinational byte-lane logic for a big-endian 32-bit memory word.
// Lane o (byte offset o inside the aligned word) lives in bits [31-8*o -: 8].
// Ports:
//   off_i      [1:0]  byte offset inside the aligned word (address bits 1:0)
//   size_i            access size (msize_e)
//   sign_i            sign-extend byte/halfword loads
//   rdata_i    [31:0] aligned word read from memory
//   wdata_i    [31:0] right-justified store data
//   load_o     [31:0] right-justified, extended load data
//   misalign_o        access violates its natural alignment
//   be_o       [3:0]  per-lane write enables, be_o[o] for offset o
//   wdata_o    [31:0] store data placed on its lanes
module ram_lane_align
    import ram_responder_pkg::*;
(
    input  logic [1:0]  off_i,
    input  msize_e      size_i,
    input  logic        sign_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the big-endian word.
    always_comb begin
        byte_s = 8'h00;
        half_s = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        case (off_i)
            2'b00:   byte_s = rdata_i[31:24];
            2'b01:   byte_s = rdata_i[23:16];
            2'b10:   byte_s = rdata_i[15:8];
            2'b11:   byte_s = rdata_i[7:0];
            default: byte_s = rdata_i[31:24];
        endcase
    end

    // Size decode: alignment check, load extension and store lane placement.
    // Store data is replicated across lanes; be_o selects which lanes land.
    always_comb begin
        load_o     = 32'h0000_0000;
        misalign_o = 1'b0;
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        case (size_i)
            MSIZE_BYTE: begin
                load_o  = extend_load({8'h00, byte_s}, 1'b0, sign_i);
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MSIZE_HALF: begin
                misalign_o = off_i[0];
                load_o     = extend_load(half_s, 1'b1, sign_i);
                wdata_o    = {2{wdata_i[15:0]}};
                if (off_i[0]) begin
                    be_o = 4'b0000;
                end else if (off_i[1]) begin
                    be_o = 4'b1100;
                end else begin
                    be_o = 4'b0011;
                end
            end
            MSIZE_WORD, MSIZE_RSVD: begin
                misalign_o = (off_i != 2'b00);
                load_o     = rdata_i;
                be_o       = (off_i != 2'b00) ? 4'b0000 : 4'b1111;
                wdata_o    = wdata_i;
            end
            default: begin
                misalign_o = (off_i != 2'b00);
                load_o     = rdata_i;
                be_o       = (off_i != 2'b00) ? 4'b0000 : 4'b1111;
                wdata_o    = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/ram_responder.sv
// ram_responder
// Byte-addressed, big-endian RAM behind a four-phase MFA/MFC handshake.
// The request is latched in IDLE, a wait counter runs in WAIT, and the
// store commits / load registers on the WAIT->DONE edge. DONE holds MFC
// until MFA drops. Dropping MFA during WAIT aborts without side effects.
// Memory is not reset; benches may preload it through mem[].
// Configuration macro: RAM_RESPONDER_WAIT_EN -- when defined the counter is
// loaded with WAIT_CYCLES, otherwise with 0 (WAIT lasts one cycle).
// Ports:
//   Clk            rising-edge clock
//   Reset          synchronous, active-low reset
//   MFA            memory function active (request)
//   MRW            1 = read, 0 = write
//   MSIZE   [1:0]  00 byte, 01 halfword, 10 word, 11 treated as word
//   MSIGN          sign-extend byte/halfword loads
//   MAR     [31:0] byte address (taken modulo DEPTH_BYTES)
//   DataIn  [31:0] right-justified store data
//   DataOut [31:0] right-justified load data
//   MFC            memory function complete
//   MAE            misaligned-address error, valid while MFC=1
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        MRW,
    input  logic [1:0]  MSIZE,
    input  logic        MSIGN,
    input  logic [31:0] MAR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MAE
);

    localparam int AW = $clog2(DEPTH_BYTES);

`ifdef RAM_RESPONDER_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] W_LOAD = WAIT_EN ? CNT_W'(WAIT_CYCLES) : {CNT_W{1'b0}};

    logic [7:0] mem [DEPTH_BYTES];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mfc_q, mfc_d;
    logic              mae_q, mae_d;
    logic [31:0]       dout_q, dout_d;

    // Request captured at the latching edge
    logic [AW-1:0]     addr_q;
    logic              rw_q;
    msize_e            size_q;
    logic              sign_q;
    logic [31:0]       din_q;

    logic              latch_s;
    logic              commit_s;
    logic [31:0]       rdata_s;
    logic [31:0]       load_s;
    logic [31:0]       wdata_s;
    logic [3:0]        be_s;
    logic              misalign_s;

    // Address bits above the memory size wrap silently.
    logic              unused_mar_hi_s;
    assign unused_mar_hi_s = ^MAR[31:AW];

    // Aligned big-endian word containing the latched address.
    assign rdata_s = {mem[{addr_q[AW-1:2], 2'b00}],
                      mem[{addr_q[AW-1:2], 2'b01}],
                      mem[{addr_q[AW-1:2], 2'b10}],
                      mem[{addr_q[AW-1:2], 2'b11}]};

    ram_lane_align u_lane_align (
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .sign_i     (sign_q),
        .rdata_i    (rdata_s),
        .wdata_i    (din_q),
        .load_o     (load_s),
        .misalign_o (misalign_s),
        .be_o       (be_s),
        .wdata_o    (wdata_s)
    );

    // Handshake next-state logic and output next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mfc_d    = mfc_q;
        mae_d    = mae_q;
        dout_d   = dout_q;
        latch_s  = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mfc_d = 1'b0;
                mae_d = 1'b0;
                if (MFA) begin
                    latch_s = 1'b1;
                    cnt_d   = W_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!MFA) begin
                    // Abort: no write, no MFC pulse.
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d  = ST_DONE;
                    mfc_d    = 1'b1;
                    mae_d    = misalign_s;
                    commit_s = !misalign_s && !rw_q;
                    if (!misalign_s && rw_q) begin
                        dout_d = load_s;
                    end else begin
                        dout_d = dout_q;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (!MFA) begin
                    mfc_d   = 1'b0;
                    mae_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                mfc_d   = 1'b0;
                mae_d   = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, output and request registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            mfc_q   <= 1'b0;
            mae_q   <= 1'b0;
            dout_q  <= 32'h0000_0000;
            addr_q  <= {AW{1'b0}};
            rw_q    <= 1'b0;
            size_q  <= MSIZE_BYTE;
            sign_q  <= 1'b0;
            din_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mfc_q   <= mfc_d;
            mae_q   <= mae_d;
            dout_q  <= dout_d;
            if (latch_s) begin
                addr_q <= MAR[AW-1:0];
                rw_q   <= MRW;
                size_q <= msize_e'(MSIZE);
                sign_q <= MSIGN;
                din_q  <= DataIn;
            end
        end
    end

    // Store commit; memory contents survive reset, and a reset edge
    // suppresses any commit that would have happened on it.
    always_ff @(posedge Clk) begin
        if (Reset && commit_s) begin
            for (int o = 0; o < 4; o++) begin
                if (be_s[o]) begin
                    mem[{addr_q[AW-1:2], 2'(o)}] <= wdata_s[31-8*o -: 8];
                end
            end
        end
    end

    assign DataOut = dout_q;
    assign MFC     = mfc_q;
    assign MAE     = mae_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
// Directed-vector bench for ram_responder. Expected data values are
// hand-computed from the preloaded memory image; expected latency follows
// the RAM_RESPONDER_WAIT_EN setting of the build.
module tb_ram_responder;

`ifdef RAM_RESPONDER_WAIT_EN
    localparam int W_EXP  = 2;
    localparam int W7_EXP = 7;
`else
    localparam int W_EXP  = 0;
    localparam int W7_EXP = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        MFA = 1'b0;
    logic        MRW = 1'b0;
    logic [1:0]  MSIZE = 2'b00;
    logic        MSIGN = 1'b0;
    logic [31:0] MAR = 32'h0;
    logic [31:0] DataIn = 32'h0;
    logic [31:0] DataOut, DataOut7;
    logic        MFC, MFC7, MAE, MAE7;

    int err_cnt = 0;
    int chk_cnt = 0;

    ram_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .MRW(MRW), .MSIZE(MSIZE),
        .MSIGN(MSIGN), .MAR(MAR), .DataIn(DataIn),
        .DataOut(DataOut), .MFC(MFC), .MAE(MAE)
    );

    ram_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(7)) dut7 (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .MRW(MRW), .MSIZE(MSIZE),
        .MSIGN(MSIGN), .MAR(MAR), .DataIn(DataIn),
        .DataOut(DataOut7), .MFC(MFC7), .MAE(MAE7)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full handshake: request, latency count, result check, optional
    // hold in DONE, then release and check MFC drops.
    task automatic run_txn(input string tag, input logic rw, input logic [1:0] size,
                           input logic sign, input logic [31:0] mar, input logic [31:0] din,
                           input logic [31:0] exp_dout, input logic exp_mae, input int hold);
        int  n;
        logic seen;
        @(negedge Clk);
        MRW = rw; MSIZE = size; MSIGN = sign; MAR = mar; DataIn = din; MFA = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge Clk); #1;
            n++;
            if (n == 1) begin
                // Inputs other than MFA must be ignored after latching.
                MRW = ~rw; MSIZE = ~size; MSIGN = ~sign; MAR = ~mar; DataIn = ~din;
            end
            seen = MFC;
        end
        check({tag, "/lat"}, 32'(n), 32'(W_EXP + 2));
        check({tag, "/dout"}, DataOut, exp_dout);
        check({tag, "/mae"}, {31'h0, MAE}, {31'h0, exp_mae});
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            check({tag, "/hold_mfc"}, {31'h0, MFC}, 32'h1);
            check({tag, "/hold_dout"}, DataOut, exp_dout);
        end
        MFA = 1'b0;
        @(posedge Clk); #1;
        check({tag, "/mfc_drop"}, {31'h0, MFC}, 32'h0);
    endtask

    initial begin
        int  n;
        logic seen;

        for (int i = 0; i < 256; i++) begin
            dut.mem[i]  = 8'h00;
            dut7.mem[i] = 8'h00;
        end
        dut.mem[0] = 8'h9C; dut.mem[1] = 8'h04; dut.mem[2] = 8'h40; dut.mem[3] = 8'h12;
        dut.mem[4] = 8'h11; dut.mem[5] = 8'h22; dut.mem[6] = 8'h33; dut.mem[7] = 8'h44;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst/mfc", {31'h0, MFC}, 32'h0);
        check("rst/mae", {31'h0, MAE}, 32'h0);
        check("rst/dout", DataOut, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;

        // Reads of the preloaded image
        run_txn("rd_w0",     1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h9C04_4012, 1'b0, 0);
        run_txn("rd_b0_s",   1'b1, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 32'hFFFF_FF9C, 1'b0, 0);
        run_txn("rd_b0_u",   1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_009C, 1'b0, 0);
        run_txn("rd_h2",     1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h0000_4012, 1'b0, 0);
        run_txn("rd_h0_s",   1'b1, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'hFFFF_9C04, 1'b0, 0);
        run_txn("rd_b3",     1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h0000_0012, 1'b0, 0);

        // Partial stores touch only their own bytes; DataOut unchanged by writes
        run_txn("wr_h6",     1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'hABCD_1234, 32'h0000_0012, 1'b0, 0);
        run_txn("rd_w4_a",   1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 32'h1122_1234, 1'b0, 0);
        run_txn("wr_b5",     1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0000_00A5, 32'h1122_1234, 1'b0, 0);
        run_txn("rd_w4_b",   1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 32'h11A5_1234, 1'b0, 0);

        // Misaligned accesses: MAE, DataOut unchanged, no write
        run_txn("rd_w2_mis", 1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'h11A5_1234, 1'b1, 0);
        run_txn("wr_w1_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'hDEAD_BEEF, 32'h11A5_1234, 1'b1, 0);
        run_txn("rd_w0_chk", 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h9C04_4012, 1'b0, 0);
        run_txn("rd_rsvd",   1'b1, 2'b11, 1'b0, 32'h0000_0004, 32'h0, 32'h11A5_1234, 1'b0, 0);
        run_txn("rd_wrap",   1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h9C04_4012, 1'b0, 0);
        run_txn("rd_w104",   1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h11A5_1234, 1'b0, 0);
        run_txn("rd_h1_mis", 1'b1, 2'b01, 1'b1, 32'h0000_0001, 32'h0, 32'h11A5_1234, 1'b1, 0);

        // Abort during WAIT: no MFC pulse, store dropped
        @(negedge Clk);
        MRW = 1'b0; MSIZE = 2'b10; MSIGN = 1'b0; MAR = 32'h0000_0008; DataIn = 32'hCAFE_F00D; MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        MFA = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            seen = seen | MFC;
        end
        check("abort/no_mfc", {31'h0, seen}, 32'h0);
        run_txn("abort/rd8", 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0000, 1'b0, 0);

        // Reset during WAIT with MFA still high: IDLE, outputs cleared, store dropped
        run_txn("pre_rst",   1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h9C04_4012, 1'b0, 0);
        @(negedge Clk);
        MRW = 1'b0; MSIZE = 2'b10; MSIGN = 1'b0; MAR = 32'h0000_000C; DataIn = 32'h1234_5678; MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("rstwait/mfc", {31'h0, MFC}, 32'h0);
        check("rstwait/dout", DataOut, 32'h0);
        check("rstwait/mae", {31'h0, MAE}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        MFA = 1'b0;
        @(posedge Clk); #1;
        check("rstwait/idle_mfc", {31'h0, MFC}, 32'h0);
        run_txn("rstwait/rdC", 1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0000, 1'b0, 0);

        // Holding MFA in DONE keeps MFC high with DataOut stable
        run_txn("hold",      1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h9C04_4012, 1'b0, 6);

        // Latency of the WAIT_CYCLES=7 instance
        @(negedge Clk);
        MRW = 1'b1; MSIZE = 2'b10; MSIGN = 1'b0; MAR = 32'h0; DataIn = 32'h0; MFA = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge Clk); #1;
            n++;
            seen = MFC7;
        end
        check("w7/lat", 32'(n), 32'(W7_EXP + 2));
        MFA = 1'b0;
        @(posedge Clk); #1;
        check("w7/mfc_drop", {31'h0, MFC7}, 32'h0);
        repeat (2) @(posedge Clk);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
